close_path_pipe: RTL
====================

# close_path_pipe

Pipelined, parametrised close-path subtractor for the dual-path floating-point adder. It computes A − B when the exponent difference is 0 or 1. Compared with the combinational close path, it adds:
- three register stages with valid/ready flow control;
- exact two's-complement negation and result-sign tracking;
- round-to-nearest-even on the guard bit;
- exact-zero and underflow flags.

It sits between the path-select/swap stage and the final result mux.

## Interface
Parameters:
- size_mantissa, 24, mantissa width M including hidden bit (1.M format)
- size_exponent, 8, biased exponent width E
- size_counter, 5, leading-zero counter width; must satisfy 2^size_counter > M+1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block accepts inputs this cycle
- m_a_number  in  M  larger-magnitude-exponent operand mantissa, hidden bit set
- m_b_number  in  M  other operand mantissa, hidden bit set
- exp_a  in  E  exponent of A (the larger exponent)
- exp_difference  in  1  0: exponents equal; 1: exp_a = exp_b + 1
- sign_a  in  1  sign of A
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- resulted_m_o  out  M  normalised, rounded mantissa, hidden bit at MSB
- resulted_e_o  out  E  result exponent
- sign_o  out  1  result sign
- zero_o  out  1  exact zero result
- underflow_o  out  1  normalisation underflowed; result flushed to zero

## Operation
Pipeline advance:
- Global enable: adv = !out_valid | out_ready.
- in_ready = adv.
- All three stages shift together when adv is 1; nothing moves when adv is 0.

S1, align and subtract:
- b_al = exp_difference ? {0, m_b[M-1:1]} : m_b.
- g = exp_difference ? m_b[0] : 0.
- d = {0, m_a, 0} − {0, b_al, g}, width M+2.
- neg = d[M+1].
- mag = neg ? −d : d, truncated to M+1 bits. This is exact two's complement, not one's complement.
- s1_sign = sign_a ^ neg.

S2, leading zeros:
- lz = count of leading zeros of mag[M:0], range 0..M+1.
- lz = M+1 means mag = 0.
- Register mag, lz, sign, exp_a.

S3, normalise, round, pack:
- n = mag << lz, width M+1.
- mant = n[M:1]; guard = n[0]. guard can only be 1 when lz = 0.
- Round-to-nearest-even (no sticky exists): round up iff guard & mant[0].
- If rounding carries out of M bits: mant = 1000…0 and exponent +1.
- e = exp_a − lz + carry, computed with E+1 bits.

Output rules:
- mag = 0: zero_o=1, m=0, e=0, sign_o=0 (+0 under RNE), underflow_o=0.
- Otherwise, exp_a − lz + carry ≤ 0: underflow_o=1, zero_o=1, m=0, e=0, sign_o = computed sign.
- Otherwise: zero_o=0, underflow_o=0, normal result.

## Timing
- Latency: exactly 3 clk edges from an accepted input (in_valid & in_ready) to out_valid, when out_ready is held 1.
- Throughput: 1 result per cycle.
- Ordering: results leave in input order; no reordering or dropping.
- Stall: with out_valid=1 and out_ready=0, the following hold until the handshake completes:
  - in_ready=0;
  - all outputs stable;
  - all stage contents frozen.
- Bubbles: in_valid=0 on an advance cycle inserts a bubble (stage valid=0). Bubbles collapse only through the normal advance and are never emitted as out_valid.
- Reset:
  - every stage valid bit clears;
  - outputs are 0: out_valid, resulted_m_o, resulted_e_o, sign_o, zero_o, underflow_o;
  - in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight results; no partial output.
- Simultaneous out_ready rising and a new input in the same cycle: both handshakes complete, and the pipeline stays full.

## Test plan
All cases use M=24, E=8, out_ready=1 unless stated.

1. Exact cancellation: a=0x800000, b=0x800000, exp_a=127, diff=0, sign_a=1 -> 3 cycles later zero_o=1, m=0, e=0, sign_o=0.
2. Massive cancellation: a=0x800000, b=0xFFFFFF, exp_a=128, diff=1 -> m=0x800000, e=104, zero_o=0, underflow_o=0.
3. Negative result: a=0x800000, b=0xC00000, exp_a=100, diff=0, sign_a=0 -> m=0x800000, e=99, sign_o=1.
4. RNE rounding:
   - Tie to even: a=0xFFFFFF, b=0x800001, diff=1, exp_a=50 -> m=0xBFFFFE, e=50.
   - Round up: a=0xFFFFFF, b=0x800003, diff=1, exp_a=50 -> m=0xBFFFFE, e=50.
5. Underflow: a=0x800000, b=0xFFFFFF, diff=1, exp_a=3 -> underflow_o=1, zero_o=1, m=0, e=0.
6. Backpressure and reset:
   - Stream 6 back-to-back inputs, then drop out_ready for 5 cycles -> in_ready=0 while stalled, outputs stable, all 6 results in order with none lost.
   - Assert rst mid-stream -> out_valid=0 on the next cycle, and no stale results afterward.

Source files
------------

// File: rtl/close_path_pipe.sv
// close_path_pipe
//   Three-stage pipelined close-path subtractor for the dual-path FP adder.
//   Computes A - B when the exponent difference is 0 or 1.
//   S1: align B, subtract, take the exact two's-complement magnitude.
//   S2: count leading zeros of the magnitude.
//   S3: normalise, round to nearest even on the guard bit, pack and flag.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           input handshake
//   m_a_number, m_b_number        1.M mantissas, hidden bit set
//   exp_a                         exponent of A (the larger one)
//   exp_difference                0: exponents equal, 1: exp_a = exp_b + 1
//   sign_a                        sign of A
//   out_valid / out_ready         output handshake
//   resulted_m_o, resulted_e_o    normalised rounded mantissa and exponent
//   sign_o, zero_o, underflow_o   result sign, exact zero, flushed underflow
module close_path_pipe #(
    parameter int size_mantissa = 24,
    parameter int size_exponent = 8,
    parameter int size_counter  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [size_mantissa-1:0] m_a_number,
    input  logic [size_mantissa-1:0] m_b_number,
    input  logic [size_exponent-1:0] exp_a,
    input  logic                     exp_difference,
    input  logic                     sign_a,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [size_mantissa-1:0] resulted_m_o,
    output logic [size_exponent-1:0] resulted_e_o,
    output logic                     sign_o,
    output logic                     zero_o,
    output logic                     underflow_o
);

    localparam int M = size_mantissa;
    localparam int E = size_exponent;
    localparam int C = size_counter;

    // Leading-zero count of an (M+1)-bit value; M+1 means the value is zero.
    function automatic logic [C-1:0] count_lz(input logic [M:0] v);
        logic [C-1:0] n;
        n = C'(M + 1);
        // Ascending scan: the highest set bit is the last one to write n.
        for (int i = 0; i <= M; i++) begin
            if (v[i]) n = C'(M - i);
        end
        return n;
    endfunction

    // Single global enable: every stage moves together or not at all.
    logic adv;

    // Stage registers
    logic         s1_valid_q, s2_valid_q, out_valid_q;
    logic [M:0]   s1_mag_q,   s2_mag_q;
    logic         s1_sign_q,  s2_sign_q;
    logic [E-1:0] s1_exp_q,   s2_exp_q;
    logic [C-1:0] s2_lz_q;

    logic [M-1:0] res_m_q,  res_m_d;
    logic [E-1:0] res_e_q,  res_e_d;
    logic         sign_q,   sign_d;
    logic         zero_q,   zero_d;
    logic         uflow_q,  uflow_d;

    // S1 combinational: align, subtract, magnitude
    logic [M-1:0] b_al;
    logic         guard_in;
    logic [M+1:0] diff_w, diff_neg;
    logic         neg;
    logic [M:0]   s1_mag_d;
    logic         s1_sign_d;

    // NOTE: every signal written in always_comb gets a value on every path
    // (here unconditionally) so no latch is inferred.
    always_comb begin
        b_al      = exp_difference ? {1'b0, m_b_number[M-1:1]} : m_b_number;
        guard_in  = exp_difference & m_b_number[0];
        diff_w    = {1'b0, m_a_number, 1'b0} - {1'b0, b_al, guard_in};
        neg       = diff_w[M+1];
        // Exact two's-complement negation, not a one's-complement shortcut.
        diff_neg  = ~diff_w + 1'b1;
        s1_mag_d  = neg ? diff_neg[M:0] : diff_w[M:0];
        s1_sign_d = sign_a ^ neg;
    end

    // S3 combinational: normalise, round, pack
    logic [M:0]   norm;
    logic [M-1:0] mant;
    logic         round_up;
    logic         carry;
    logic [M-1:0] mant_r;
    logic [E:0]   e_wide;
    logic         is_zero;
    logic         is_uflow;

    always_comb begin
        norm             = s2_mag_q << s2_lz_q;
        mant             = norm[M:1];
        // No sticky bits exist here, so a tie is exactly guard=1 with nothing below.
        round_up         = norm[0] & mant[0];
        {carry, mant_r}  = {1'b0, mant} + {{M{1'b0}}, round_up};
        if (carry) mant_r = {1'b1, {(M-1){1'b0}}};
        // E+1 bits; a set top bit means the exponent went negative.
        e_wide   = {1'b0, s2_exp_q} - (E+1)'(s2_lz_q) + (E+1)'(carry);
        is_zero  = (s2_mag_q == '0);
        is_uflow = !is_zero && (e_wide[E] || e_wide == '0);

        res_m_d  = '0;
        res_e_d  = '0;
        sign_d   = 1'b0;
        zero_d   = 1'b0;
        uflow_d  = 1'b0;
        if (s2_valid_q) begin
            if (is_zero) begin
                zero_d  = 1'b1;          // +0 under round-to-nearest-even
            end else if (is_uflow) begin
                zero_d  = 1'b1;
                uflow_d = 1'b1;
                sign_d  = s2_sign_q;
            end else begin
                res_m_d = mant_r;
                res_e_d = e_wide[E-1:0];
                sign_d  = s2_sign_q;
            end
        end
    end

    assign adv      = !out_valid_q | out_ready;
    assign in_ready = adv;

    // NOTE: state updates use non-blocking assignments so all stages sample
    // their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            res_m_q     <= '0;
            res_e_q     <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            uflow_q     <= 1'b0;
        end else if (adv) begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            res_m_q     <= res_m_d;
            res_e_q     <= res_e_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
            uflow_q     <= uflow_d;
        end
    end

    // NOTE: internal datapath registers carry no reset; their valid bits
    // guard them, so only valids and visible outputs are cleared.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_mag_q  <= s1_mag_d;
            s1_sign_q <= s1_sign_d;
            s1_exp_q  <= exp_a;
            s2_mag_q  <= s1_mag_q;
            s2_lz_q   <= count_lz(s1_mag_q);
            s2_sign_q <= s1_sign_q;
            s2_exp_q  <= s1_exp_q;
        end
    end

    assign out_valid    = out_valid_q;
    assign resulted_m_o = res_m_q;
    assign resulted_e_o = res_e_q;
    assign sign_o       = sign_q;
    assign zero_o       = zero_q;
    assign underflow_o  = uflow_q;

endmodule
